// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface prog_loader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IADDR = 16
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             mem_we;
  logic [IADDR-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  modport master (output in_valid, in_data, input in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: length header + little-endian words into imem, then releases the core.
// Optional trailer checksum enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IADDR     = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset,
  prog_loader_if.slave     bus,
  output logic [WIDTH-1:0] init_pc,
  output logic             core_reset_n,
  input  logic             core_fin,
  output logic             done,
  output logic             error
);
  localparam int unsigned WCW  = IADDR - 2;
  localparam logic [31:0] MAXW = 32'(((64'd1 << IADDR) - 64'(BASE_ADDR)) >> 2);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_SUM,
`endif
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t POST_LOAD = S_SUM;
`else
  localparam state_t POST_LOAD = S_RUN;
`endif

  state_t           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]   word_cnt_q, word_cnt_d;
  logic [WCW-1:0]   last_q, last_d;
  logic [WIDTH-9:0] shift_q, shift_d;
  logic             in_ready_q, in_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [IADDR-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic             core_reset_n_q, core_reset_n_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] sum_q, sum_d;
`endif

  logic             accept;
  logic [WIDTH-1:0] word_full;

  assign accept    = bus.in_valid && in_ready_q;
  assign word_full = {bus.in_data, shift_q};

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    word_cnt_d     = word_cnt_q;
    last_d         = last_q;
    shift_d        = shift_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    core_reset_n_d = core_reset_n_q;
    done_d         = done_q;
    error_d        = error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d          = sum_q;
`endif

    if (accept) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = word_full[WIDTH-1:8];
    end

    case (state_q)
      S_LEN: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d = '0;
`endif
        if (accept && byte_cnt_q == 2'd3) begin
          word_cnt_d = '0;
          last_d     = WCW'(word_full - 32'd1);
          if (word_full == '0) begin
            state_d = POST_LOAD;
          end else if (word_full > MAXW) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && byte_cnt_q == 2'd3) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = IADDR'(BASE_ADDR) + {word_cnt_q, 2'b00};
          mem_wdata_d = word_full;
          word_cnt_d  = word_cnt_q + WCW'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d       = sum_q + word_full;
`endif
          if (word_cnt_q == last_q) state_d = POST_LOAD;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_SUM: begin
        if (accept && byte_cnt_q == 2'd3) begin
          if (word_full == sum_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
`endif
      // Release lags entry by one edge so the last write never overlaps it
      S_RUN: begin
        core_reset_n_d = 1'b1;
        if (core_reset_n_q && core_fin) begin
          state_d = S_HALT;
          done_d  = 1'b1;
        end
      end
      S_HALT: done_d = 1'b1;
      S_ERR:  core_reset_n_d = 1'b0;
      default: state_d = S_LEN;
    endcase

`ifdef PROG_LOADER_CHECKSUM_EN
    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_SUM);
`else
    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_LEN;
      byte_cnt_q     <= '0;
      word_cnt_q     <= '0;
      last_q         <= '0;
      shift_q        <= '0;
      in_ready_q     <= 1'b1;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      core_reset_n_q <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      word_cnt_q     <= word_cnt_d;
      last_q         <= last_d;
      shift_q        <= shift_d;
      in_ready_q     <= in_ready_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      core_reset_n_q <= core_reset_n_d;
      done_q         <= done_d;
      error_q        <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign init_pc       = WIDTH'(BASE_ADDR);
  assign core_reset_n  = core_reset_n_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: expected imem writes are queued by the
// stimulus and popped by an independent write monitor.
module tb_prog_loader;
  localparam int unsigned IADDR = 16;
  localparam int unsigned BASE  = 0;
  localparam longint unsigned MAXW = ((longint'(1) << IADDR) - BASE) / 4;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] init_pc;
  logic        core_reset_n;
  logic        core_fin;
  logic        done;
  logic        error;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  prog_loader_if #(.WIDTH(32), .IADDR(IADDR)) bus ();

  prog_loader #(.WIDTH(32), .IADDR(IADDR), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .init_pc      (init_pc),
    .core_reset_n (core_reset_n),
    .core_fin     (core_fin),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every mem_we cycle must match the next queued expectation
  always @(negedge clk) begin
    if (!reset && bus.mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write at %0t",
                 bus.mem_addr, bus.mem_wdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.mem_addr !== mon_e.addr || bus.mem_wdata !== mon_e.data) begin
          errors++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   bus.mem_addr, bus.mem_wdata, mon_e.addr, mon_e.data);
        end
      end
      check("core_held_during_write", core_reset_n, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_checks();
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_core_reset_n", core_reset_n, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_init_pc", init_pc, 32'(BASE));
  endtask

  // Asserted between edges so the clear must happen asynchronously
  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 reset_checks();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), gaps);
  endtask

  // Reference: N words land at BASE+4k; oversize headers are rejected outright
  task automatic load(input logic [31:0] n, input logic [31:0] words[$], input bit gaps);
    logic [31:0] sum;
    sum = '0;
    send_word(n, gaps);
    if (longint'(n) > MAXW) begin
      check("err_flag", error, 1'b1);
      check("err_in_ready", bus.in_ready, 1'b0);
      check("err_core_reset_n", core_reset_n, 1'b0);
      repeat (3) @(negedge clk);
      check("err_no_write", 64'(exp_q.size()), 64'd0);
      check("err_sticky", error, 1'b1);
      check("err_core_held", core_reset_n, 1'b0);
      return;
    end
    for (int k = 0; k < words.size(); k++) begin
      exp_q.push_back('{addr: 16'(BASE + 4 * k), data: words[k]});
      sum += words[k];
      send_word(words[k], gaps);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(sum, gaps);
`endif
    check("core_low_after_last", core_reset_n, 1'b0);
    @(negedge clk);
    check("core_released", core_reset_n, 1'b1);
    check("run_in_ready", bus.in_ready, 1'b0);
    check("run_error", error, 1'b0);
    check("run_done_not_yet", done, 1'b0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    check("run_init_pc", init_pc, 32'(BASE));
  endtask

  task automatic fin_pulse();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("run_refuses_bytes", bus.in_ready, 1'b0);
    core_fin = 1'b1;
    @(negedge clk);
    core_fin = 1'b0;
    check("done_set", done, 1'b1);
    repeat (3) @(negedge clk);
    check("done_sticky", done, 1'b1);
    check("halt_core_on", core_reset_n, 1'b1);
    check("halt_in_ready", bus.in_ready, 1'b0);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] n;
    reset        = 1'b1;
    core_fin     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #2 reset_checks();
    @(negedge clk);
    reset = 1'b0;

    // Two-word program at full rate
    w = '{32'h0000_0013, 32'h0010_0093};
    load(32'd2, w, 1'b0);
    fin_pulse();

    // Empty image
    apply_reset();
    w = {};
    load(32'd0, w, 1'b0);

    // Oversize header; fin must be ignored in ERR
    apply_reset();
    load(32'(MAXW + 1), w, 1'b0);
    core_fin = 1'b1;
    repeat (2) @(negedge clk);
    core_fin = 1'b0;
    check("err_fin_ignored", done, 1'b0);

    // Toggled valid, fin held high across release: sampled only after core_reset_n rises
    apply_reset();
    core_fin = 1'b1;
    repeat (3) @(negedge clk);
    check("len_fin_ignored", done, 1'b0);
    check("len_in_ready", bus.in_ready, 1'b1);
    w = '{32'hDEAD_BEEF};
    load(32'd1, w, 1'b1);
    @(negedge clk);
    core_fin = 1'b0;
    check("fin_after_release", done, 1'b1);

    // Reset partway through word 1 discards it; reload starts at BASE again
    apply_reset();
    send_word(32'd3, 1'b0);
    exp_q.push_back('{addr: 16'(BASE), data: 32'hCAFE_0001});
    send_word(32'hCAFE_0001, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    apply_reset();
    check("midload_drained", 64'(exp_q.size()), 64'd0);
    w = '{32'h1234_5678, 32'h9ABC_DEF0};
    load(32'd2, w, 1'b0);
    fin_pulse();

    // Random images, occasional rejected header
    for (int it = 0; it < 10; it++) begin
      apply_reset();
      w = {};
      if ($urandom_range(0, 4) == 0) begin
        n = 32'(MAXW + 1) + 32'($urandom_range(0, 1000));
        if ($urandom_range(0, 1) == 1) n = 32'hFFFF_FFFF;
      end else begin
        n = 32'($urandom_range(0, 6));
        for (int k = 0; k < int'(n); k++) w.push_back($urandom);
      end
      load(n, w, 1'($urandom_range(0, 1)));
      if (longint'(n) <= MAXW && $urandom_range(0, 1) == 1) fin_pulse();
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Wrong trailer is rejected and the core stays held
    apply_reset();
    send_word(32'd2, 1'b0);
    exp_q.push_back('{addr: 16'(BASE), data: 32'h1});
    exp_q.push_back('{addr: 16'(BASE + 4), data: 32'h2});
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    send_word(32'h4, 1'b0);
    check("sum_bad_error", error, 1'b1);
    check("sum_bad_in_ready", bus.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    check("sum_bad_core_held", core_reset_n, 1'b0);
    check("sum_bad_drained", 64'(exp_q.size()), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
